// File: rtl/serdes_pkg.sv
// Shared types and constants for the SERDES transmit scheduler.
package serdes_pkg;

    localparam logic [3:0] HDR_SYNC = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [7:0]        byte_t;

    // Index width that stays legal (>= 1 bit) for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and wraps.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            if (i_req[(int'(i_last) + off) % NUM_SRC]) begin
                o_grant = '0;
                o_grant[(int'(i_last) + off) % NUM_SRC] = 1'b1;
                o_idx   = IDX_W'((int'(i_last) + off) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Arbitrates AXIS sources and serialises each accepted word as a header byte
// followed by its bytes, little-endian, into a downstream byte FIFO.
module serdes_tx_scheduler
    import serdes_pkg::*;
#(
    parameter int LOGIC_SIZE = 32,
    parameter int NUM_SRC    = 2
) (
    input  logic                                m_axis_aclk,
    input  logic                                m_axis_reset_n,
    input  logic [NUM_SRC-1:0][LOGIC_SIZE-1:0]  m_axis_tdata,
    input  logic [NUM_SRC-1:0]                  m_axis_valid,
    output logic [NUM_SRC-1:0]                  m_axis_ready,
    output logic [7:0]                          o_to_fifo,
    input  logic                                w_full,
    output logic                                w_req
);

    localparam int BYTES  = LOGIC_SIZE / 8;
    localparam int IDX_W  = idx_w(NUM_SRC);
    localparam int BIDX_W = idx_w(BYTES);

    state_t                  r_state;
    logic [BIDX_W-1:0]       r_idx;
    logic [BYTES-1:0][7:0]   r_hold;
    logic [IDX_W-1:0]        r_src;
    logic [IDX_W-1:0]        r_last;

    logic [NUM_SRC-1:0]      w_grant;
    logic [IDX_W-1:0]        w_gidx;
    logic                    w_hs;
    byte_t                   w_byte;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (m_axis_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    // Ready is gated by reset so nothing is offered while the block is held.
    assign m_axis_ready = (r_state == ST_IDLE && m_axis_reset_n) ? w_grant : '0;
    assign w_hs         = |(m_axis_valid & m_axis_ready);
    assign w_req        = (r_state != ST_IDLE) && !w_full;

    always_comb begin
        w_byte = '0;
        case (r_state)
            ST_HDR:  w_byte = {HDR_SYNC, 4'(r_src)};
            ST_DATA: w_byte = r_hold[r_idx];
            default: w_byte = '0;
        endcase
    end
    assign o_to_fifo = w_byte;

    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_src   <= '0;
            r_last  <= IDX_W'(NUM_SRC - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_hold  <= m_axis_tdata[w_gidx];
                        r_src   <= w_gidx;
                        r_last  <= w_gidx;
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!w_full) begin
                        r_idx   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!w_full) begin
                        if (r_idx == BIDX_W'(BYTES - 1)) begin
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + BIDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/serdes_tx_scheduler.md
SERDES_TX_SCHEDULER -- requirements
Module: serdes_tx_scheduler

Interface
REQ-001 SHALL have parameter LOGIC_SIZE, default 32, meaning AXIS word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning number of AXIS manager sources; legal range 1..16.
REQ-003 SHALL have port m_axis_aclk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port m_axis_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port m_axis_tdata  input  NUM_SRC x LOGIC_SIZE  per-source word data.
REQ-006 SHALL have port m_axis_valid  input  NUM_SRC  per-source valid.
REQ-007 SHALL have port m_axis_ready  output  NUM_SRC  per-source ready, at most one bit high.
REQ-008 SHALL have port o_to_fifo  output  8  byte written to the downstream byte FIFO.
REQ-009 SHALL have port w_full  input  1  downstream FIFO full.
REQ-010 SHALL have port w_req  output  1  downstream FIFO write strobe.

Function
REQ-011 SHALL implement FSM states IDLE, HDR, DATA; BYTES = LOGIC_SIZE/8.
REQ-012 In IDLE, m_axis_ready SHALL be combinationally one-hot on the round-robin winner among asserted m_axis_valid bits; all zero if none valid or state != IDLE.
REQ-013 Round-robin SHALL search from (last_grant+1) mod NUM_SRC upward with wrap; last_grant updates only on a completed handshake.
REQ-014 On handshake (valid && ready) SHALL capture the word into a holding register, latch the source index, and go to HDR next cycle.
REQ-015 In HDR, w_req SHALL equal !w_full; o_to_fifo = {4'hA, source index[3:0]}; on w_req, go to DATA with byte index 0.
REQ-016 In DATA, w_req SHALL equal !w_full; o_to_fifo = holding byte [idx*8 +: 8], little-endian (byte 0 first).
REQ-017 In DATA, on w_req: idx increments; when idx == BYTES-1, SHALL return to IDLE and reset idx to 0.
REQ-018 With w_full high, SHALL hold state, idx and o_to_fifo; w_req stays 0; no byte is lost or repeated.
REQ-019 o_to_fifo SHALL be 0 whenever state is IDLE.
REQ-020 Latency: handshake in cycle N -> header write earliest cycle N+1 -> last data byte earliest N+1+BYTES; next handshake earliest N+2+BYTES (one IDLE bubble per word).
REQ-021 A source dropping valid before grant SHALL simply lose arbitration; no state change.
REQ-022 NUM_SRC=1 SHALL degenerate to a fixed grant with identical framing.

Reset
REQ-023 On m_axis_reset_n low, SHALL asynchronously enter IDLE, idx=0, holding register=0, source index=0, last_grant=NUM_SRC-1 (so source 0 wins first).
REQ-024 During reset, m_axis_ready=0, w_req=0, o_to_fifo=0.
REQ-025 Reset mid-frame SHALL discard the in-flight word; no partial frame continues after release.

Structure
REQ-026 Package serdes_pkg SHALL hold: header sync nibble constant 4'hA, FSM state enum, data_t/byte_t typedefs.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last_grant in; one-hot grant and index out; purely combinational).
REQ-028 FSM, counters and holding register SHALL reside in serdes_tx_scheduler.

Verification
REQ-029 Single word: src0 tdata=0x11223344, w_full=0 -> w_req bytes 0xA0,0x44,0x33,0x22,0x11 in 5 consecutive cycles, ready high 1 cycle.
REQ-030 Contention: src0 and src1 valid continuously with 0xAAAA0000/0xBBBB1111 -> frames alternate headers 0xA0,0xA1,0xA0,...
REQ-031 Backpressure: w_full high 3 cycles after header -> w_req 0 for 3 cycles, o_to_fifo held at 0x44, stream resumes with no duplicate/missing byte.
REQ-032 Reset mid-frame: assert reset after 2nd data byte -> w_req=0, ready=0 immediately; after release first grant goes to src0, new full frame.
REQ-033 Idle: all valid=0 for 20 cycles -> w_req never high, o_to_fifo=0, ready=0.
REQ-034 Scoreboard: random valid/w_full on 4 sources -> every accepted word reappears exactly once as header+4 bytes, per-source order preserved.
